sw_debounce: RTL and testbench
==============================

# sw_debounce

Synchronizes and debounces the board slide switches before they reach the Chapter 2 full adder. It is the stage directly upstream of the adder's 3-bit switch input. Each raw `SW` bit passes through a two-flop synchronizer and then a per-bit stability counter. The clean, registered result drives the adder's carry-in, A and B inputs.

## Interface
- `NUM_SW`, default 3: number of switch bits. Bit 2 is carry-in, bit 1 is A, bit 0 is B. Range 1..16.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required to accept a change. This is 10 ms at 100 MHz. Minimum 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SW`  in  NUM_SW  raw, asynchronous, bouncing switch inputs.
- `SW_CLEAN`  out  NUM_SW  debounced switch levels, registered. Feeds the adder's `SW`.
- `SW_RISE`  out  NUM_SW  one-cycle pulse per bit on an accepted 0→1 change. Present only with `SW_DEBOUNCE_PULSE_EN`.
- `SW_FALL`  out  NUM_SW  one-cycle pulse per bit on an accepted 1→0 change. Present only with `SW_DEBOUNCE_PULSE_EN`.

## Operation
- Bits are fully independent; there is no cross-bit interaction.
- Per bit, the state is:
  - `sync1` and `sync2`: synchronizer flops.
  - `stable`: drives `SW_CLEAN`.
  - `cnt`: `CNT_W = $clog2(DEBOUNCE_CYCLES)` bits.
- Each clock edge:
  - `sync1 <= SW`, `sync2 <= sync1`.
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- The block behaves as a two-state machine per bit:
  - IDLE (`cnt == 0`, `sync2 == stable`).
  - COUNTING (`sync2 != stable`).
  - Any return of `sync2` to `stable` while COUNTING aborts to IDLE with `cnt = 0`. The output does not change.
- Counter never wraps. Its maximum value is `DEBOUNCE_CYCLES-1`, after which it is forced to 0.
- Reset values: `sync1`, `sync2`, `stable`, `cnt` = 0. Therefore `SW_CLEAN` = 0, and `SW_RISE`/`SW_FALL` = 0.
- Reset asserted mid-count: all state clears immediately (asynchronous), with no pulse generated.
- After reset release with a switch held high, `SW_CLEAN` rises after the normal latency. `SW_RISE` pulses for that transition.

## Timing
- Latency: a clean `SW` change sampled at edge k appears on `SW_CLEAN` after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles.
- Rejection: a pulse on `sync2` lasting fewer than DEBOUNCE_CYCLES cycles never reaches `SW_CLEAN`.
- Acceptance: a pulse lasting exactly DEBOUNCE_CYCLES cycles is accepted.
- `SW_RISE`/`SW_FALL` are asserted in the same cycle `SW_CLEAN` changes, for exactly one cycle.
- Simultaneous changes on several bits are processed in parallel with identical latency.

## Configuration
- `SW_DEBOUNCE_PULSE_EN` defined:
  - `SW_RISE` and `SW_FALL` ports and their registers exist.
  - `SW_RISE = stable & ~stable_d`, registered so it aligns with `SW_CLEAN`. `SW_FALL` likewise.
- Not defined: those ports and their logic are absent. `SW_CLEAN` behaviour is identical in both cases.

## Structure
- Package `debounce_pkg`:
  - `DEFAULT_DEBOUNCE_CYCLES`.
  - Function for `CNT_W` with a floor of 1.
  - `typedef enum logic {IDLE, COUNTING}` for coverage and debug.
- Sub-module `debounce_bit`: single-bit synchronizer, counter and stable register. Instantiated NUM_SW times via generate in `sw_debounce`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_SW=3.
- Reset: hold `rst_n`=0 with `SW`=3'b111. Required: `SW_CLEAN`=0 and pulses 0. Release; `SW_CLEAN`=3'b111 exactly 6 cycles later, and `SW_RISE`=3'b111 for one cycle (macro on).
- Clean edge: `SW[1]` 0→1 and held. Required: `SW_CLEAN[1]` rises 6 cycles after the sampling edge; other bits unchanged.
- Bounce rejection: `SW[0]` toggles high for 3 cycles then low, repeated 5 times. Required: `SW_CLEAN[0]` stays 0 and no pulses.
- Bounce then settle: `SW[2]` bounces 1-2-cycle pulses for 10 cycles, then holds 1. Required: `SW_CLEAN[2]` rises 6 cycles after the final settle edge.
- Reset mid-count: `SW`=3'b010, assert `rst_n`=0 at count 2 for 1 cycle. Required: `SW_CLEAN`=0 during reset; rises 6 cycles after release.
- Fall and all bits: `SW` 3'b111→3'b000 simultaneously. Required: `SW_CLEAN` 3'b000 after 6 cycles, and `SW_FALL`=3'b111 for exactly one cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helper and per-bit state encoding for the
// switch debouncer.
`timescale 1ns/1ps
package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

    // Counter width for a given stability window, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and accepted level.
// Edge pulses exist only when SW_DEBOUNCE_PULSE_EN is defined.
`timescale 1ns/1ps
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
`ifdef SW_DEBOUNCE_PULSE_EN
    output logic rise,
    output logic fall,
`endif
    output logic clean
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_nxt_s;
    logic             accept_s;
    db_state_e        state_s;

    // State register: synchronizer, counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r  <= sw;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Next-state: count while the synchronized input disagrees, accept at the limit.
    always_comb begin
        cnt_nxt_s    = '0;
        stable_nxt_s = stable_r;
        accept_s     = 1'b0;
        case (state_s)
            IDLE: begin
                cnt_nxt_s = '0;
            end
            COUNTING: begin
                if (cnt_r == CNT_MAX) begin
                    accept_s     = 1'b1;
                    stable_nxt_s = sync2_r;
                    cnt_nxt_s    = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt_s = '0;
            end
        endcase
    end

    // Output decode: per-bit state and the registered clean level.
    always_comb begin
        state_s = (sync2_r != stable_r) ? COUNTING : IDLE;
        clean   = stable_r;
    end

`ifdef SW_DEBOUNCE_PULSE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses registered on the same edge that updates the clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= accept_s & sync2_r;
            fall_r <= accept_s & ~sync2_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces NUM_SW board switches (bit 2 carry-in, bit 1 A, bit 0 B).
// Optional SW_RISE/SW_FALL pulses under macro SW_DEBOUNCE_PULSE_EN.
`timescale 1ns/1ps
module sw_debounce
    import debounce_pkg::*;
#(
    parameter int NUM_SW          = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] SW,
`ifdef SW_DEBOUNCE_PULSE_EN
    output logic [NUM_SW-1:0] SW_RISE,
    output logic [NUM_SW-1:0] SW_FALL,
`endif
    output logic [NUM_SW-1:0] SW_CLEAN
);

    // Bits are fully independent, so each gets its own debouncer.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .sw   (SW[i]),
`ifdef SW_DEBOUNCE_PULSE_EN
            .rise (SW_RISE[i]),
            .fall (SW_FALL[i]),
`endif
            .clean(SW_CLEAN[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Cycle-by-cycle vector bench for sw_debounce with DEBOUNCE_CYCLES=4, NUM_SW=3.
`timescale 1ns/1ps
module tb_sw_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw;
    logic [2:0] sw_clean;
`ifdef SW_DEBOUNCE_PULSE_EN
    logic [2:0] sw_rise;
    logic [2:0] sw_fall;
`endif

    sw_debounce #(
        .NUM_SW(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SW      (sw),
`ifdef SW_DEBOUNCE_PULSE_EN
        .SW_RISE (sw_rise),
        .SW_FALL (sw_fall),
`endif
        .SW_CLEAN(sw_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sw;
        logic       rst_n;
        logic [2:0] clean;
        logic [2:0] rise;
        logic [2:0] fall;
        int         tag;
    } vec_t;

    typedef struct {
        logic [2:0] clean;
        logic [2:0] rise;
        logic [2:0] fall;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Append n identical cycles: inputs applied, outputs required after the edge.
    task automatic add(input int n, input logic [2:0] s, input logic r,
                       input logic [2:0] c, input logic [2:0] ri,
                       input logic [2:0] fa, input int tag);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.sw = s; v.rst_n = r; v.clean = c;
            v.rise = (k == 0) ? ri : 3'b000;
            v.fall = (k == 0) ? fa : 3'b000;
            v.tag = tag;
            vecs.push_back(v);
        end
    endtask

    initial begin
        exp_t e;
        exp_t got;
        // 1: reset held with switches high, then latency after release
        add(3, 3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1);
        add(5, 3'b111, 1'b1, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b111, 1'b1, 3'b111, 3'b111, 3'b000, 1);
        add(2, 3'b111, 1'b1, 3'b111, 3'b000, 3'b000, 1);
        // 2: all bits fall together
        add(5, 3'b000, 1'b1, 3'b111, 3'b000, 3'b000, 2);
        add(1, 3'b000, 1'b1, 3'b000, 3'b000, 3'b111, 2);
        add(2, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 2);
        // 3: clean edge on bit 1
        add(5, 3'b010, 1'b1, 3'b000, 3'b000, 3'b000, 3);
        add(1, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 3);
        add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 3);
        // 4: bit 0 high 3 cycles, repeated: must be rejected
        for (int r = 0; r < 5; r++) begin
            add(3, 3'b011, 1'b1, 3'b010, 3'b000, 3'b000, 4);
            add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 4);
        end
        add(4, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 4);
        // 5: bit 0 high exactly 4 cycles: accepted, then falls back
        add(4, 3'b011, 1'b1, 3'b010, 3'b000, 3'b000, 5);
        add(1, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 5);
        add(1, 3'b010, 1'b1, 3'b011, 3'b001, 3'b000, 5);
        add(3, 3'b010, 1'b1, 3'b011, 3'b000, 3'b000, 5);
        add(1, 3'b010, 1'b1, 3'b010, 3'b000, 3'b001, 5);
        add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 5);
        // 6: bit 2 bounces 1-2 cycle pulses for 10 cycles, then settles high
        add(2, 3'b110, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(1, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(1, 3'b110, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(2, 3'b110, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(5, 3'b110, 1'b1, 3'b010, 3'b000, 3'b000, 6);
        add(1, 3'b110, 1'b1, 3'b110, 3'b100, 3'b000, 6);
        add(2, 3'b110, 1'b1, 3'b110, 3'b000, 3'b000, 6);
        // 7: return to zero, then reset in the middle of a count
        add(5, 3'b000, 1'b1, 3'b110, 3'b000, 3'b000, 7);
        add(1, 3'b000, 1'b1, 3'b000, 3'b000, 3'b110, 7);
        add(2, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 7);
        add(4, 3'b010, 1'b1, 3'b000, 3'b000, 3'b000, 7);
        add(1, 3'b010, 1'b0, 3'b000, 3'b000, 3'b000, 7);
        add(5, 3'b010, 1'b1, 3'b000, 3'b000, 3'b000, 7);
        add(1, 3'b010, 1'b1, 3'b010, 3'b010, 3'b000, 7);
        add(2, 3'b010, 1'b1, 3'b010, 3'b000, 3'b000, 7);

        sw    = 3'b111;
        rst_n = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            sw    = vecs[i].sw;
            rst_n = vecs[i].rst_n;
            e.clean = vecs[i].clean;
            e.rise  = vecs[i].rise;
            e.fall  = vecs[i].fall;
            e.tag   = vecs[i].tag;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            checks++;
            if (sw_clean !== got.clean) begin
                errors++;
                $display("FAIL clean scen=%0d vec=%0d actual=%b required=%b",
                         got.tag, i, sw_clean, got.clean);
            end
`ifdef SW_DEBOUNCE_PULSE_EN
            checks++;
            if (sw_rise !== got.rise) begin
                errors++;
                $display("FAIL rise scen=%0d vec=%0d actual=%b required=%b",
                         got.tag, i, sw_rise, got.rise);
            end
            checks++;
            if (sw_fall !== got.fall) begin
                errors++;
                $display("FAIL fall scen=%0d vec=%0d actual=%b required=%b",
                         got.tag, i, sw_fall, got.fall);
            end
`endif
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
